// File: rtl/lif_mon_pkg.sv
// Shared types and default sizing for the LIF spike monitor.
package lif_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2
  } state_t;

  localparam int CNT_W_DEF      = 8;
  localparam int ISI_W_DEF      = 8;
  localparam int WINDOW_LEN_DEF = 256;

endpackage

// File: rtl/lif_sat_counter.sv
// Saturating up-counter; clr zeroes first, so clr together with inc loads 1.
module lif_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= {{(W-1){1'b0}}, inc};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Spike-train monitor: per-window spike rate and inter-spike interval.
//   state  | meaning
//   IDLE   | disabled, counters held at 0, outputs hold last values
//   ARMED  | window running, waiting for the first event to start ISI timing
//   TIMING | window running, ISI timer counting since the last event
module lif_spike_monitor
  import lif_mon_pkg::*;
#(
  parameter int WINDOW_LEN = WINDOW_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ISI_W      = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             isi_ovf,
  output logic             busy
);

  localparam int WCW = $clog2(WINDOW_LEN);
  localparam logic [WCW-1:0] WLAST = WCW'(WINDOW_LEN - 1);

  state_t           state;
  logic             spike_q;
  logic [WCW-1:0]   wcnt;
  logic [CNT_W-1:0] scnt;
  logic [ISI_W-1:0] timer;

  logic             spk_evt;
  logic             active;
  logic             win_close;
  logic             scnt_clr, scnt_inc;
  logic             tmr_clr, tmr_inc;
  logic [CNT_W:0]   rate_sum;
  logic [CNT_W-1:0] rate_sat;

  assign spk_evt   = spike & ~spike_q;
  assign active    = en && (state != IDLE);
  assign win_close = active && (wcnt == WLAST);

  // An event on the closing cycle goes into rate_out, not into the next window.
  assign scnt_clr = ~active | win_close;
  assign scnt_inc = active & spk_evt & ~win_close;
  assign tmr_clr  = ~active | spk_evt;
  assign tmr_inc  = active & (spk_evt | (state == TIMING));

  assign rate_sum = {1'b0, scnt} + {{CNT_W{1'b0}}, spk_evt};
  assign rate_sat = rate_sum[CNT_W] ? {CNT_W{1'b1}} : rate_sum[CNT_W-1:0];

  lif_sat_counter #(.W(CNT_W)) u_scnt (
    .clk (clk),
    .rst (rst),
    .clr (scnt_clr),
    .inc (scnt_inc),
    .cnt (scnt)
  );

  lif_sat_counter #(.W(ISI_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .cnt (timer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      spike_q    <= 1'b0;
      wcnt       <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
      isi_ovf    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      spike_q    <= spike;
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      wcnt       <= (!active || win_close) ? '0 : wcnt + WCW'(1);
      if (win_close) begin
        rate_out   <= rate_sat;
        rate_valid <= 1'b1;
      end
      // Every enabled state leads to ARMED or TIMING, so busy simply follows en.
      busy <= en;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= ARMED;
          ARMED:   if (spk_evt) state <= TIMING;
          TIMING: begin
            if (spk_evt) begin
              isi_out   <= timer;
              isi_valid <= 1'b1;
              isi_ovf   <= (timer == {ISI_W{1'b1}});
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor using three parameterisations on shared inputs.
module tb_lif_spike_monitor;

  logic clk = 1'b0;
  logic rst, en, spike;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] a_rate, c_rate, a_isi, b_isi, c_isi;
  logic [2:0] b_rate;
  logic a_rv, a_iv, a_ovf, a_busy;
  logic b_rv, b_iv, b_ovf, b_busy;
  logic c_rv, c_iv, c_ovf, c_busy;

  always #5 clk = ~clk;

  lif_spike_monitor #(.WINDOW_LEN(16), .CNT_W(8), .ISI_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .spike(spike),
    .rate_out(a_rate), .rate_valid(a_rv), .isi_out(a_isi),
    .isi_valid(a_iv), .isi_ovf(a_ovf), .busy(a_busy));

  lif_spike_monitor #(.WINDOW_LEN(16), .CNT_W(3), .ISI_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .spike(spike),
    .rate_out(b_rate), .rate_valid(b_rv), .isi_out(b_isi),
    .isi_valid(b_iv), .isi_ovf(b_ovf), .busy(b_busy));

  lif_spike_monitor #(.WINDOW_LEN(4), .CNT_W(8), .ISI_W(8)) u_c (
    .clk(clk), .rst(rst), .en(en), .spike(spike),
    .rate_out(c_rate), .rate_valid(c_rv), .isi_out(c_isi),
    .isi_valid(c_iv), .isi_ovf(c_ovf), .busy(c_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUTs reset and disabled; the caller raises en and ticks once (edge k=0).
  task automatic do_reset;
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      spike = i[0];
      tick;
      total++;
      if ({a_rate, a_rv, a_isi, a_iv, a_ovf, a_busy} !== 20'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, {a_rate, a_rv, a_isi, a_iv, a_ovf, a_busy});
      end
    end
    rst = 1'b0; spike = 1'b0;
    tick;
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_after_reset got=%b exp=1", a_busy); end
    total++;
    if ({a_rv, a_iv} !== 2'b00) begin bad++; $display("FAIL valids_after_reset got=%b exp=00", {a_rv, a_iv}); end
  endtask

  task automatic test_window_isi;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 48; k++) begin
      spike = (k % 4 == 1);
      tick;
      total++;
      if (a_rv !== (k % 16 == 0)) begin bad++; $display("FAIL win_rate_valid k=%0d got=%b", k, a_rv); end
      if (k % 16 == 0) begin
        total++;
        if (a_rate !== 8'd4) begin bad++; $display("FAIL win_rate_out k=%0d got=%0d exp=4", k, a_rate); end
      end
      total++;
      if (a_iv !== (k % 4 == 1 && k > 1)) begin bad++; $display("FAIL win_isi_valid k=%0d got=%b", k, a_iv); end
      if (k % 4 == 1 && k > 1) begin
        total++;
        if (a_isi !== 8'd4 || a_ovf !== 1'b0) begin
          bad++; $display("FAIL win_isi k=%0d got=%0d ovf=%b exp=4 ovf=0", k, a_isi, a_ovf);
        end
      end
    end
  endtask

  task automatic test_held_spike;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 32; k++) begin
      spike = (k <= 10);
      tick;
      total++;
      if (a_iv !== 1'b0) begin bad++; $display("FAIL held_isi_valid k=%0d got=%b exp=0", k, a_iv); end
      if (k == 16 || k == 32) begin
        total++;
        if (a_rv !== 1'b1 || a_rate !== ((k == 16) ? 8'd1 : 8'd0)) begin
          bad++; $display("FAIL held_rate k=%0d got=%0d valid=%b exp=%0d", k, a_rate, a_rv, (k == 16) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_isi_saturation;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 310; k++) begin
      spike = (k == 1 || k == 301 || k == 306);
      tick;
      total++;
      if (a_iv !== (k == 301 || k == 306)) begin bad++; $display("FAIL sat_isi_valid k=%0d got=%b", k, a_iv); end
      if (k == 301) begin
        total++;
        if (a_isi !== 8'd255 || a_ovf !== 1'b1) begin
          bad++; $display("FAIL sat_isi_ovf got=%0d ovf=%b exp=255 ovf=1", a_isi, a_ovf);
        end
      end
      if (k == 306) begin
        total++;
        if (a_isi !== 8'd5 || a_ovf !== 1'b0) begin
          bad++; $display("FAIL sat_isi_recover got=%0d ovf=%b exp=5 ovf=0", a_isi, a_ovf);
        end
      end
    end
  endtask

  task automatic test_rate_saturation;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 32; k++) begin
      spike = (k % 2 == 1);
      tick;
      total++;
      if (b_rv !== (k % 16 == 0)) begin bad++; $display("FAIL sat_rate_valid k=%0d got=%b", k, b_rv); end
      if (k % 16 == 0) begin
        total++;
        if (b_rate !== 3'd7) begin bad++; $display("FAIL sat_rate_cnt3 k=%0d got=%0d exp=7", k, b_rate); end
        total++;
        if (a_rate !== 8'd8) begin bad++; $display("FAIL sat_rate_cnt8 k=%0d got=%0d exp=8", k, a_rate); end
      end
    end
  endtask

  task automatic test_last_cycle_event;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 8; k++) begin
      spike = (k == 4);
      tick;
      total++;
      if (c_rv !== (k % 4 == 0)) begin bad++; $display("FAIL last_rate_valid k=%0d got=%b", k, c_rv); end
      if (k % 4 == 0) begin
        total++;
        if (c_rate !== ((k == 4) ? 8'd1 : 8'd0)) begin
          bad++; $display("FAIL last_rate_out k=%0d got=%0d exp=%0d", k, c_rate, (k == 4) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_enable_drop;
    do_reset; en = 1'b1; tick;
    for (int k = 1; k <= 34; k++) begin
      en    = !(k >= 10 && k <= 14);
      spike = (k == 2 || k == 12 || k == 20 || k == 25);
      tick;
      total++;
      if (a_busy !== !(k >= 10 && k <= 14)) begin bad++; $display("FAIL drop_busy k=%0d got=%b", k, a_busy); end
      total++;
      if (a_rv !== (k == 31)) begin bad++; $display("FAIL drop_rate_valid k=%0d got=%b", k, a_rv); end
      total++;
      if (a_iv !== (k == 25)) begin bad++; $display("FAIL drop_isi_valid k=%0d got=%b", k, a_iv); end
      if (k == 25) begin
        total++;
        if (a_isi !== 8'd5) begin bad++; $display("FAIL drop_isi_out got=%0d exp=5", a_isi); end
      end
      if (k == 31) begin
        total++;
        if (a_rate !== 8'd2) begin bad++; $display("FAIL drop_rate_out got=%0d exp=2", a_rate); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spike = 1'b0;
    test_reset;
    test_window_isi;
    test_held_spike;
    test_isi_saturation;
    test_rate_saturation;
    test_last_cycle_event;
    test_enable_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
